relu_maxpool_stream: RTL and testbench

Streaming post-processing stage that sits directly downstream of `conv_engine`. It consumes the engine's raster-ordered signed 32-bit convolution results, one beat per valid cycle, and applies ReLU and a right-shift requantization with saturation to int8. It then performs non-overlapping 2x2 max pooling and writes the pooled int8 map to the next layer's feature memory. The default configuration gives a 28x28 input map and a 14x14 output map, which is the C1→S2 stage of the LeNet-style pipeline.

---
 rtl/relu_maxpool_stream.sv | 118 +++++++++++
 tb/tb_relu_maxpool_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stream.sv
// ReLU + shift requantization to int8, then non-overlapping 2x2 max pooling of a
// raster-ordered conv result stream; one pooled write per completed window.
module relu_maxpool_stream #(
    parameter int IN_DIM = 28,
    parameter int SHIFT = 8,
    localparam int OUT_DIM = IN_DIM / 2,
    localparam int AW = (OUT_DIM * OUT_DIM > 1) ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          out_wr_en,
    output logic [AW-1:0] out_wr_addr,
    output logic [7:0]    out_wr_data,
    output logic          done
);

    localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int LW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);

    if (IN_DIM % 2 != 0) begin : g_dim_check
        $error("IN_DIM must be even");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] row, col;
    logic [7:0]    pair;
    logic [AW-1:0] waddr;
    logic          fin;
    logic [7:0]    linebuf [OUT_DIM];

    logic          accept;
    logic [7:0]    qx, hmax, lb_rd, pooled;
    logic [LW-1:0] lb_idx;

    function automatic logic [7:0] quant(input logic signed [31:0] x);
        logic signed [31:0] y;
        if (x < 0) return 8'd0;
        y = x >>> SHIFT;
        if (y > 32'sd127) return 8'd127;
        return y[7:0];
    endfunction

    always_comb begin
        accept = in_valid && (state == RUN);
        qx     = quant(in_data);
        hmax   = (pair > qx) ? pair : qx;
        lb_idx = LW'(col >> 1);
        lb_rd  = linebuf[lb_idx];
        pooled = (lb_rd > hmax) ? lb_rd : hmax;
    end

    // fin delays done by one edge so it rises after the final write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            pair        <= '0;
            waddr       <= '0;
            fin         <= 1'b0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            done        <= 1'b0;
        end else begin
            out_wr_en <= 1'b0;
            fin       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        row   <= '0;
                        col   <= '0;
                        waddr <= '0;
                        done  <= 1'b0;
                    end else if (fin) begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!col[0]) begin
                            pair <= qx;
                        end else if (row[0]) begin
                            out_wr_en   <= 1'b1;
                            out_wr_addr <= waddr;
                            out_wr_data <= pooled;
                            waddr       <= waddr + 1'b1;
                        end
                        if (col == LAST) begin
                            col <= '0;
                            row <= (row == LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (row == LAST && col == LAST) begin
                            state <= DONE;
                            fin   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) linebuf[lb_idx] <= hmax;
    end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Bench for relu_maxpool_stream: two instances (SHIFT=4 and SHIFT=2) share one stimulus
// stream; expected pooled writes are queued at drive time and popped on each write.
module tb_relu_maxpool_stream;

    localparam int N = 28;
    localparam int M = 14;
    localparam int NT = 12;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [31:0] in_data;
    logic        wr_en4, wr_en2, done4, done2;
    logic [7:0]  addr4, addr2, data4, data2;

    always #5 clk = ~clk;

    relu_maxpool_stream #(.IN_DIM(N), .SHIFT(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_wr_en(wr_en4), .out_wr_addr(addr4), .out_wr_data(data4), .done(done4)
    );

    relu_maxpool_stream #(.IN_DIM(N), .SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_wr_en(wr_en2), .out_wr_addr(addr2), .out_wr_data(data2), .done(done2)
    );

    typedef struct {
        logic [3:0][31:0] x;
        logic [7:0]       e4;
        logic [7:0]       e2;
    } vec_t;

    vec_t        tbl [NT];
    logic [15:0] exp4_q[$];
    logic [15:0] exp2_q[$];
    logic [31:0] fx [N*N];
    logic [7:0]  cap4 [M*M];
    logic [7:0]  cap2 [M*M];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt4 = 0;
    int          wr_cnt2 = 0;
    logic        pool_beat;
    logic        exp_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] qref(input logic [31:0] x, input int sh);
        int signed v;
        v = signed'(x);
        if (v < 0) return 8'd0;
        v = v >>> sh;
        return (v > 127) ? 8'd127 : v[7:0];
    endfunction

    function automatic logic [7:0] win_ref(input int r, input int c, input int sh);
        logic [7:0] m, t;
        m = 8'd0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                t = qref(fx[(r - 1 + dr) * N + c - 1 + dc], sh);
                if (t > m) m = t;
            end
        return m;
    endfunction

    task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d,
                           input logic [7:0] e4, input logic [7:0] e2);
        tbl[k].x[0] = a; tbl[k].x[1] = b; tbl[k].x[2] = c; tbl[k].x[3] = d;
        tbl[k].e4 = e4;  tbl[k].e2 = e2;
    endtask

    function automatic logic [31:0] beat_val(input int mode, input int i);
        int r, c;
        r = i / N; c = i % N;
        case (mode)
            0: return 32'(i);
            1: return -32'sd1000;
            default: return (r < 2 && c / 2 < NT) ? tbl[c / 2].x[r * 2 + c % 2] : 32'd0;
        endcase
    endfunction

    // Expected write flag: a write must follow exactly the accepted window-closing beats.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_wr <= 1'b0;
        else     exp_wr <= pool_beat;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (wr_en4 || exp_wr) chk("wr_en4_timing", 32'(wr_en4), 32'(exp_wr));
        if (wr_en2 || exp_wr) chk("wr_en2_timing", 32'(wr_en2), 32'(exp_wr));
        if (wr_en4) begin
            wr_cnt4++;
            cap4[addr4] = data4;
            if (exp4_q.size() == 0) chk("spurious_wr4", {addr4, data4}, 32'hffff_ffff);
            else begin e = exp4_q.pop_front(); chk("wr4_addr_data", {addr4, data4}, 32'(e)); end
        end
        if (wr_en2) begin
            wr_cnt2++;
            cap2[addr2] = data2;
            if (exp2_q.size() == 0) chk("spurious_wr2", {addr2, data2}, 32'hffff_ffff);
            else begin e = exp2_q.pop_front(); chk("wr2_addr_data", {addr2, data2}, 32'(e)); end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("done4_cleared", 32'(done4), 0);
        chk("done2_cleared", 32'(done2), 0);
        wr_cnt4 = 0; wr_cnt2 = 0;
    endtask

    task automatic run_frame(input int mode, input int gap, input int abort_at, input bit start_mid);
        int r, c, k;
        logic [7:0] e4, e2;
        for (int i = 0; i < N * N; i++) begin
            if (i == abort_at) return;
            fx[i] = beat_val(mode, i);
            r = i / N; c = i % N;
            @(negedge clk);
            in_valid = 1'b1; in_data = fx[i];
            start = start_mid && (i == 100);
            pool_beat = (r % 2 == 1) && (c % 2 == 1);
            if (pool_beat) begin
                k = (r / 2) * M + c / 2;
                if (mode == 2) begin
                    e4 = (k < NT) ? tbl[k].e4 : 8'd0;
                    e2 = (k < NT) ? tbl[k].e2 : 8'd0;
                end else begin
                    e4 = win_ref(r, c, 4);
                    e2 = win_ref(r, c, 2);
                end
                exp4_q.push_back({8'(k), e4});
                exp2_q.push_back({8'(k), e2});
            end
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0; start = 1'b0; pool_beat = 1'b0; in_data = $urandom;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; pool_beat = 1'b0;
    endtask

    task automatic frame_check(input string tag);
        @(negedge clk);
        chk({tag, "_count4"}, wr_cnt4, M * M);
        chk({tag, "_count2"}, wr_cnt2, M * M);
        chk({tag, "_q4_empty"}, exp4_q.size(), 0);
        chk({tag, "_q2_empty"}, exp2_q.size(), 0);
        chk({tag, "_done4"}, 32'(done4), 1);
        chk({tag, "_done2"}, 32'(done2), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_out4"}, {wr_en4, addr4, data4, done4}, 0);
        chk({tag, "_out2"}, {wr_en2, addr2, data2, done2}, 0);
    endtask

    task automatic idle_pulses();
        int c4, c2;
        c4 = wr_cnt4; c2 = wr_cnt2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid = i[0]; in_data = 32'd5000 + 32'(i);
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_wr4", wr_cnt4, c4);
        chk("idle_no_wr2", wr_cnt2, c2);
        chk("idle_done4", 32'(done4), 0);
    endtask

    initial begin
        set_vec(0,  -32'sd5, -32'sd7, 32'd300, -32'sd1,      8'd18,  8'd75);
        set_vec(1,  32'd0, 32'h7fff_ffff, 32'd0, 32'd0,      8'd127, 8'd127);
        set_vec(2,  32'd16, 32'd32, 32'd48, 32'd64,          8'd4,   8'd16);
        set_vec(3,  -32'sd1, -32'sd2, -32'sd3, -32'sd4,      8'd0,   8'd0);
        set_vec(4,  32'd508, 32'd0, 32'd0, 32'd0,            8'd31,  8'd127);
        set_vec(5,  32'd512, 32'd0, 32'd0, 32'd0,            8'd32,  8'd127);
        set_vec(6,  32'd2047, 32'd0, 32'd0, 32'd2048,        8'd127, 8'd127);
        set_vec(7,  32'd15, 32'd3, 32'd0, 32'd0,             8'd0,   8'd3);
        set_vec(8,  32'h8000_0000, 32'd100, 32'd0, 32'd0,    8'd6,   8'd25);
        set_vec(9,  32'd0, 32'd0, 32'd0, 32'd2032,           8'd127, 8'd127);
        set_vec(10, 32'd0, 32'd0, 32'd2031, 32'd0,           8'd126, 8'd127);
        set_vec(11, 32'd63, 32'd0, 32'd0, 32'd0,             8'd3,   8'd15);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; pool_beat = 1'b0;
        #12;
        check_outputs_zero("reset_init");
        @(negedge clk); rst = 1'b0;
        idle_pulses();

        pulse_start();
        run_frame(0, 0, -1, 1'b0);
        chk("ramp_done4_early", 32'(done4), 0);
        chk("ramp_wr4_last", 32'(wr_en4), 1);
        @(negedge clk);
        chk("ramp_done4_two_edges", 32'(done4), 1);
        chk("ramp_done2_two_edges", 32'(done2), 1);
        chk("ramp_count4", wr_cnt4, M * M);
        chk("ramp_addr0", 32'(cap4[0]), 1);
        chk("ramp_addr13", 32'(cap4[13]), 3);
        chk("ramp_addr195", 32'(cap4[195]), 48);
        chk("ramp_sh2_addr0", 32'(cap2[0]), 7);
        chk("ramp_sh2_addr195", 32'(cap2[195]), 127);

        @(posedge clk); #3 rst = 1'b1;
        #1 check_outputs_zero("reset_async");
        @(negedge clk); rst = 1'b0;
        idle_pulses();

        pulse_start();
        run_frame(1, 0, -1, 1'b0);
        frame_check("negative");

        pulse_start();
        run_frame(2, 0, -1, 1'b0);
        frame_check("table");
        for (int k = 0; k < NT; k++) begin
            chk($sformatf("table_vec%0d_sh4", k), 32'(cap4[k]), 32'(tbl[k].e4));
            chk($sformatf("table_vec%0d_sh2", k), 32'(cap2[k]), 32'(tbl[k].e2));
        end

        pulse_start();
        run_frame(0, 2, -1, 1'b0);
        frame_check("gapped");
        chk("gapped_addr0", 32'(cap4[0]), 1);
        chk("gapped_addr195", 32'(cap4[195]), 48);

        pulse_start();
        run_frame(0, 0, -1, 1'b1);
        frame_check("start_in_run");

        pulse_start();
        run_frame(0, 0, 401, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset_midframe");
        chk("midframe_q4_empty", exp4_q.size(), 0);
        exp4_q.delete(); exp2_q.delete();
        @(negedge clk); rst = 1'b0;
        pulse_start();
        run_frame(0, 0, -1, 1'b0);
        frame_check("after_reset");
        chk("after_reset_addr13", 32'(cap4[13]), 3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
